// File: rtl/fetch_unit.sv
// Instruction fetch front end: walks the asynchronous instruction ROM and
// feeds decode through a 2-entry buffer over a valid/ready handshake.
//
// Ports:
//   i_clk, i_reset     clock, synchronous active-high reset
//   i_fetch_en         1 = fetch, 0 = pause (buffer contents kept)
//   o_rom_addr         ROM word address, straight from the fetch PC
//   i_rom_dout         ROM word, combinational on o_rom_addr
//   i_redirect         1-cycle pulse: flush, restart at i_redirect_pc
//   i_redirect_pc      byte target, bits [1:0] ignored
//   o_instr_valid      buffer head holds an instruction
//   i_instr_ready      decode takes the head on valid & ready
//   o_instr, o_instr_pc  head word and its byte PC
//   o_addr_err         1-cycle pulse: redirect target out of range
module fetch_unit #(
  parameter int          D_WIDTH   = 32,
  parameter int          MEM_DEPTH = 1000,
  parameter logic [31:0] RESET_PC  = 32'h0,
  localparam int         A_WIDTH   = $clog2(MEM_DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_fetch_en,
  output logic [A_WIDTH-1:0] o_rom_addr,
  input  logic [D_WIDTH-1:0] i_rom_dout,
  input  logic               i_redirect,
  input  logic [31:0]        i_redirect_pc,
  output logic               o_instr_valid,
  input  logic               i_instr_ready,
  output logic [D_WIDTH-1:0] o_instr,
  output logic [31:0]        o_instr_pc,
  output logic               o_addr_err
);

  localparam logic [A_WIDTH-1:0] RST_IDX =
    RESET_PC[A_WIDTH+1:2];
  localparam logic [A_WIDTH-1:0] LAST_IDX =
    A_WIDTH'(MEM_DEPTH - 1);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [A_WIDTH-1:0] r_fpc;
  logic [1:0]         r_count;
  logic [D_WIDTH-1:0] r_hd_data;
  logic [A_WIDTH-1:0] r_hd_idx;
  logic [D_WIDTH-1:0] r_e1_data;
  logic [A_WIDTH-1:0] r_e1_idx;
  logic               r_addr_err;

  logic               w_pop;
  logic               w_push;
  logic               w_oor;
  logic [A_WIDTH-1:0] w_fpc_inc;
  logic               w_unused_lsb;

  assign w_unused_lsb = ^i_redirect_pc[1:0];

  // valid depends on state only, never on ready
  assign o_instr_valid = (r_count != 2'd0);
  assign w_pop = o_instr_valid & i_instr_ready;

  assign w_oor = {2'b00, i_redirect_pc[31:2]}
                 >= 32'(MEM_DEPTH);

  // depth need not be a power of two: wrap explicitly
  assign w_fpc_inc = (r_fpc == LAST_IDX)
                     ? '0 : r_fpc + A_WIDTH'(1);

  assign o_rom_addr = r_fpc;
  assign o_instr    = r_hd_data;
  assign o_instr_pc = {{(30-A_WIDTH){1'b0}}, r_hd_idx, 2'b00};
  assign o_addr_err = r_addr_err;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_fetch_en) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!i_fetch_en) w_state_nxt = S_IDLE;
        // a full buffer still takes a word if the head leaves
        w_push = (r_count != 2'd2) || w_pop;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_fpc      <= RST_IDX;
      r_count    <= 2'd0;
      r_hd_data  <= '0;
      r_hd_idx   <= '0;
      r_e1_data  <= '0;
      r_e1_idx   <= '0;
      r_addr_err <= 1'b0;
    end else begin
      r_addr_err <= 1'b0;
      if (i_redirect) begin
        // flush; any pop this edge counts as taken
        r_count <= 2'd0;
        if (w_oor) begin
          r_fpc      <= '0;
          r_addr_err <= 1'b1;
        end else begin
          r_fpc <= i_redirect_pc[A_WIDTH+1:2];
        end
      end else begin
        if (w_push) r_fpc <= w_fpc_inc;
        case ({w_push, w_pop})
          2'b10: begin
            if (r_count == 2'd0) begin
              r_hd_data <= i_rom_dout;
              r_hd_idx  <= r_fpc;
            end else begin
              r_e1_data <= i_rom_dout;
              r_e1_idx  <= r_fpc;
            end
            r_count <= r_count + 2'd1;
          end
          2'b01: begin
            r_hd_data <= r_e1_data;
            r_hd_idx  <= r_e1_idx;
            r_count   <= r_count - 2'd1;
          end
          2'b11: begin
            if (r_count == 2'd1) begin
              r_hd_data <= i_rom_dout;
              r_hd_idx  <= r_fpc;
            end else begin
              r_hd_data <= r_e1_data;
              r_hd_idx  <= r_e1_idx;
              r_e1_data <= i_rom_dout;
              r_e1_idx  <= r_fpc;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand sequences,
// then random traffic against a queue-based reference model.
module tb_fetch_unit;

  localparam int DEPTH = 1000;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [31:0] RPC = 32'h0;

  logic          clk = 1'b0;
  logic          rst, en, rdy, redir;
  logic [31:0]   rpc;
  logic [AW-1:0] rom_addr;
  logic [31:0]   rom_dout;
  logic          valid, addr_err;
  logic [31:0]   instr, instr_pc;

  int checks   = 0;
  int failures = 0;

  int m_q[$];
  int m_fpc;
  bit m_run;
  bit m_err;

  always #5 clk = ~clk;

  assign rom_dout = 32'hA000_0000 + 32'(rom_addr);

  fetch_unit #(
    .D_WIDTH(32), .MEM_DEPTH(DEPTH), .RESET_PC(RPC)
  ) dut (
    .i_clk(clk),
    .i_reset(rst),
    .i_fetch_en(en),
    .o_rom_addr(rom_addr),
    .i_rom_dout(rom_dout),
    .i_redirect(redir),
    .i_redirect_pc(rpc),
    .o_instr_valid(valid),
    .i_instr_ready(rdy),
    .o_instr(instr),
    .o_instr_pc(instr_pc),
    .o_addr_err(addr_err)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // reference: buffer is a queue of word indices
  task automatic model(input logic r, e, y, d,
                       input logic [31:0] p);
    bit pop, push;
    if (r) begin
      m_q.delete();
      m_fpc = int'(RPC >> 2);
      m_run = 0;
      m_err = 0;
    end else begin
      pop  = (m_q.size() > 0) && y;
      push = m_run && (m_q.size() < 2 || pop);
      m_err = 0;
      if (d) begin
        m_q.delete();
        if ((p >> 2) >= 32'(DEPTH)) begin
          m_fpc = 0;
          m_err = 1;
        end else begin
          m_fpc = int'(p >> 2);
        end
      end else begin
        if (pop) void'(m_q.pop_front());
        if (push) begin
          m_q.push_back(m_fpc);
          m_fpc = (m_fpc + 1) % DEPTH;
        end
      end
      m_run = e;
    end
  endtask

  task automatic step(input logic r, e, y, d,
                      input logic [31:0] p);
    rst = r; en = e; rdy = y; redir = d; rpc = p;
    @(posedge clk);
    model(r, e, y, d, p);
    #1;
  endtask

  typedef struct {
    logic        r, e, y, d;
    logic [31:0] p;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] eins;
    logic [31:0] ead;
    logic        eerr;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(
      logic r, e, y, d, logic [31:0] p,
      logic ev, logic [31:0] epc,
      logic [31:0] ead, logic eerr);
    vec_t v;
    v.r = r; v.e = e; v.y = y; v.d = d; v.p = p;
    v.ev = ev; v.epc = epc;
    v.eins = r ? 32'h0 : 32'hA000_0000 + (epc >> 2);
    v.ead = ead; v.eerr = eerr;
    return v;
  endfunction

  initial begin
    rst = 1; en = 0; rdy = 0; redir = 0; rpc = 0;

    // reset, start, stream
    tv.push_back(mk(1,1,1,0,0,     0,32'h000,0,0));
    tv.push_back(mk(0,1,1,0,0,     0,32'h000,0,0));
    tv.push_back(mk(0,1,1,0,0,     1,32'h000,1,0));
    tv.push_back(mk(0,1,1,0,0,     1,32'h004,2,0));
    tv.push_back(mk(0,1,1,0,0,     1,32'h008,3,0));
    // fill to 2, redirect to 0x103
    tv.push_back(mk(0,1,0,0,0,     1,32'h008,4,0));
    tv.push_back(mk(0,1,0,0,0,     1,32'h008,4,0));
    tv.push_back(mk(0,1,0,1,'h103, 0,32'h000,'h40,0));
    tv.push_back(mk(0,1,1,0,0,     1,32'h100,'h41,0));
    // redirect to last word, wrap
    tv.push_back(mk(0,1,1,1,'hF9C, 0,32'h000,999,0));
    tv.push_back(mk(0,1,1,0,0,     1,32'hF9C,0,0));
    tv.push_back(mk(0,1,1,0,0,     1,32'h000,1,0));
    tv.push_back(mk(0,1,1,0,0,     1,32'h004,2,0));
    // out-of-range redirect
    tv.push_back(mk(0,1,1,1,'h1000,0,32'h000,0,1));
    tv.push_back(mk(0,1,1,0,0,     1,32'h000,1,0));
    tv.push_back(mk(0,1,1,0,0,     1,32'h004,2,0));
    // reset with a full buffer
    tv.push_back(mk(0,1,0,0,0,     1,32'h004,3,0));
    tv.push_back(mk(1,1,0,0,0,     0,32'h000,0,0));
    tv.push_back(mk(0,1,1,0,0,     0,32'h000,0,0));
    tv.push_back(mk(0,1,1,0,0,     1,32'h000,1,0));
    tv.push_back(mk(0,1,1,0,0,     1,32'h004,2,0));
    // pause, redirect while idle, resume
    tv.push_back(mk(0,0,1,0,0,     1,32'h008,3,0));
    tv.push_back(mk(0,0,1,0,0,     0,32'h000,3,0));
    tv.push_back(mk(0,0,1,1,'h200, 0,32'h000,'h80,0));
    tv.push_back(mk(0,1,1,0,0,     0,32'h000,'h80,0));
    tv.push_back(mk(0,1,1,0,0,     1,32'h200,'h81,0));

    for (int i = 0; i < tv.size(); i++) begin
      step(tv[i].r, tv[i].e, tv[i].y, tv[i].d, tv[i].p);
      chk($sformatf("v%0d_valid", i), 32'(valid),
          32'(tv[i].ev));
      chk($sformatf("v%0d_addr", i), 32'(rom_addr),
          tv[i].ead);
      chk($sformatf("v%0d_err", i), 32'(addr_err),
          32'(tv[i].eerr));
      if (tv[i].ev || tv[i].r) begin
        chk($sformatf("v%0d_pc", i), instr_pc, tv[i].epc);
        chk($sformatf("v%0d_instr", i), instr, tv[i].eins);
      end
    end

    // stall 5 cycles: head at 0x200, buffer fills, addr frozen
    for (int k = 0; k < 5; k++) begin
      step(0, 1, 0, 0, 0);
      chk("stall_valid", 32'(valid), 32'd1);
      chk("stall_pc", instr_pc, 32'h200);
      chk("stall_instr", instr, 32'hA000_0080);
      chk("stall_addr", 32'(rom_addr), 32'h82);
    end
    // release: consecutive PCs, no loss or duplicate
    for (int k = 1; k <= 6; k++) begin
      step(0, 1, 1, 0, 0);
      chk("drain_valid", 32'(valid), 32'd1);
      chk("drain_pc", instr_pc, 32'h200 + 32'(4 * k));
      chk("drain_instr", instr,
          32'hA000_0080 + 32'(k));
    end

    // random traffic vs. reference model
    step(1, 0, 0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      logic r, e, y, d;
      logic [31:0] p;
      r = ($urandom_range(0, 99) == 0);
      e = ($urandom_range(0, 99) < 85);
      y = ($urandom_range(0, 99) < 70);
      d = ($urandom_range(0, 99) < 5);
      case ($urandom_range(0, 3))
        0: p = 32'($urandom_range(0, 3999));
        1: p = 32'hF9C + 32'($urandom_range(0, 3));
        2: p = $urandom;
        default: p = 32'($urandom_range(3990, 4100));
      endcase
      step(r, e, y, d, p);
      chk("rnd_valid", 32'(valid), 32'(m_q.size() > 0));
      chk("rnd_addr", 32'(rom_addr), 32'(m_fpc));
      chk("rnd_err", 32'(addr_err), 32'(m_err));
      if (m_q.size() > 0) begin
        chk("rnd_pc", instr_pc, 32'(m_q[0] * 4));
        chk("rnd_instr", instr,
            32'hA000_0000 + 32'(m_q[0]));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
